// File: rtl/ram_sp_clr.sv
// ram_sp_clr: parametrised single-port RAM with hardware clear sweep,
// configurable read latency/write mode and a one-cycle DVALID strobe.
module ram_sp_clr #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 8,
  parameter int DEPTH = 2**ADDR_W,
  parameter logic [DATA_W-1:0] CLR_VAL = '0,
  parameter int READ_LAT = 1,
  parameter int WR_MODE = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              WE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] Din,
  input  logic              CLR,
  output logic [DATA_W-1:0] Dout,
  output logic              DVALID,
  output logic              BUSY
);
  typedef enum logic {CLEAR, IDLE} state_t;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH-1);
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  state_t state;
  logic [ADDR_W:0] clr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic acc, hit, v_new, s_v, out_v;
  logic [DATA_W-1:0] rd_word, d_new, s_d, out_d;
  // a CLR in IDLE wins over any same-cycle access
  assign acc = state == IDLE && EN && !CLR;
  assign hit = {1'b0, ADDR} < DEPTH_W;
  assign rd_word = hit ? mem[ADDR] : CLR_VAL;
  assign v_new = acc && !(WE && WR_MODE == 2);
  assign d_new = (WE && WR_MODE == 1) ? Din : rd_word;
  assign out_v = READ_LAT == 2 ? s_v : v_new;
  assign out_d = READ_LAT == 2 ? s_d : d_new;
  always_ff @(posedge CLK) begin
    if (state == CLEAR)
      mem[clr_ptr[ADDR_W-1:0]] <= CLR_VAL;
    else if (acc && WE && hit)
      mem[ADDR] <= Din;
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= CLEAR;
      clr_ptr <= '0;
      BUSY <= 1'b1;
    end else if (CLR) begin
      state <= CLEAR;
      clr_ptr <= '0;
      BUSY <= 1'b1;
    end else if (state == CLEAR) begin
      state <= clr_ptr == LAST ? IDLE : CLEAR;
      BUSY <= clr_ptr != LAST;
      clr_ptr <= clr_ptr == LAST ? '0 : clr_ptr + 1'b1;
    end
  end
  // s_v/s_d form the extra output stage, bypassed when READ_LAT is 1
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s_v <= 1'b0;
      s_d <= '0;
      DVALID <= 1'b0;
      Dout <= '0;
    end else begin
      s_v <= v_new;
      if (v_new) s_d <= d_new;
      DVALID <= out_v;
      if (out_v) Dout <= out_d;
    end
  end
endmodule

// File: tb/tb_ram_sp_clr.sv
// tb_ram_sp_clr: directed checks of ram_sp_clr across several parameter sets
// driven from one shared stimulus.
module tb_ram_sp_clr;
  logic CLK = 0, RST = 1, EN = 0, WE = 0, CLR = 0;
  logic [7:0] ADDR = 0;
  logic [9:0] Din = 0;
  logic [9:0] dout0, dout1, dout2, dout3, dout4;
  logic dv0, dv1, dv2, dv3, dv4, busy0, busy1, busy2, busy3, busy4;
  int total = 0, bad = 0;

  always #5 CLK = ~CLK;

  ram_sp_clr u0 (.CLK(CLK), .RST(RST), .EN(EN), .WE(WE), .ADDR(ADDR), .Din(Din), .CLR(CLR),
                 .Dout(dout0), .DVALID(dv0), .BUSY(busy0));
  ram_sp_clr #(.WR_MODE(1)) u1 (.CLK(CLK), .RST(RST), .EN(EN), .WE(WE), .ADDR(ADDR), .Din(Din),
                 .CLR(CLR), .Dout(dout1), .DVALID(dv1), .BUSY(busy1));
  ram_sp_clr #(.READ_LAT(2)) u2 (.CLK(CLK), .RST(RST), .EN(EN), .WE(WE), .ADDR(ADDR), .Din(Din),
                 .CLR(CLR), .Dout(dout2), .DVALID(dv2), .BUSY(busy2));
  ram_sp_clr #(.DEPTH(200), .CLR_VAL(10'h3FF)) u3 (.CLK(CLK), .RST(RST), .EN(EN), .WE(WE),
                 .ADDR(ADDR), .Din(Din), .CLR(CLR), .Dout(dout3), .DVALID(dv3), .BUSY(busy3));
  ram_sp_clr #(.WR_MODE(2)) u4 (.CLK(CLK), .RST(RST), .EN(EN), .WE(WE), .ADDR(ADDR), .Din(Din),
                 .CLR(CLR), .Dout(dout4), .DVALID(dv4), .BUSY(busy4));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    int n = 0, n3 = 0;
    #1 RST = 0;
    #1;
    total++;
    if ({dout0, dv0, busy0} !== {10'd0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL reset_state dout=%0d dv=%b busy=%b want 0/0/1", dout0, dv0, busy0);
    end
    tick(); tick();
    RST = 1;
    while (busy0 && n < 400) begin
      if (busy3) n3++;
      tick(); n++;
    end
    total++;
    if (n !== 256) begin bad++; $display("FAIL sweep_len got=%0d want=256", n); end
    total++;
    if (n3 !== 200) begin bad++; $display("FAIL sweep_len_d200 got=%0d want=200", n3); end
    EN = 1; WE = 0;
    for (int i = 0; i < 256; i++) begin
      ADDR = 8'(i);
      tick();
      total++;
      if ({dv0, dout0} !== {1'b1, 10'd0}) begin
        bad++; $display("FAIL clear_read a=%0d dv=%b dout=%0d want 1/0", i, dv0, dout0);
      end
    end
    EN = 0;
    tick();
  endtask

  task automatic test_write_read();
    EN = 1; WE = 1; ADDR = 0; Din = 29; tick();
    ADDR = 1; Din = 45; tick();
    WE = 0; ADDR = 1; tick();
    total++;
    if ({dv0, dout0} !== {1'b1, 10'd45}) begin
      bad++; $display("FAIL read1 dv=%b dout=%0d want 1/45", dv0, dout0);
    end
    ADDR = 0; tick();
    total++;
    if ({dv0, dout0} !== {1'b1, 10'd29}) begin
      bad++; $display("FAIL read0 dv=%b dout=%0d want 1/29", dv0, dout0);
    end
    EN = 0; tick();
    total++;
    if ({dv0, dout0} !== {1'b0, 10'd29}) begin
      bad++; $display("FAIL idle_hold dv=%b dout=%0d want 0/29", dv0, dout0);
    end
  endtask

  task automatic test_wr_mode();
    EN = 1; WE = 1; ADDR = 3; Din = 565; tick();
    total++;
    if ({dv0, dout0} !== {1'b1, 10'd0}) begin
      bad++; $display("FAIL rf_write1 dv=%b dout=%0d want 1/0", dv0, dout0);
    end
    total++;
    if ({dv1, dout1} !== {1'b1, 10'd565}) begin
      bad++; $display("FAIL wf_write1 dv=%b dout=%0d want 1/565", dv1, dout1);
    end
    total++;
    if ({dv4, dout4} !== {1'b0, 10'd29}) begin
      bad++; $display("FAIL nc_write1 dv=%b dout=%0d want 0/29", dv4, dout4);
    end
    Din = 0; tick();
    total++;
    if ({dv0, dout0} !== {1'b1, 10'd565}) begin
      bad++; $display("FAIL rf_write2 dv=%b dout=%0d want 1/565", dv0, dout0);
    end
    total++;
    if ({dv1, dout1} !== {1'b1, 10'd0}) begin
      bad++; $display("FAIL wf_write2 dv=%b dout=%0d want 1/0", dv1, dout1);
    end
    WE = 0; tick();
    total++;
    if ({dv0, dout0} !== {1'b1, 10'd0}) begin
      bad++; $display("FAIL raw_read3 dv=%b dout=%0d want 1/0", dv0, dout0);
    end
    total++;
    if ({dv4, dout4} !== {1'b1, 10'd0}) begin
      bad++; $display("FAIL nc_read3 dv=%b dout=%0d want 1/0", dv4, dout4);
    end
    EN = 0; tick();
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp [3];
    exp[0] = 29; exp[1] = 45; exp[2] = 77;
    EN = 1; WE = 1; ADDR = 2; Din = 77; tick();
    EN = 0; tick(); tick();
    EN = 1; WE = 0; ADDR = 0; tick();
    total++;
    if (dv2 !== 1'b0) begin bad++; $display("FAIL lat2_early dv=%b want 0", dv2); end
    for (int i = 0; i < 3; i++) begin
      EN = i < 2; ADDR = 8'(i + 1); tick();
      total++;
      if ({dv2, dout2} !== {1'b1, exp[i]}) begin
        bad++; $display("FAIL lat2_b2b i=%0d dv=%b dout=%0d want 1/%0d", i, dv2, dout2, exp[i]);
      end
    end
    tick();
    total++;
    if ({dv2, dout2} !== {1'b0, 10'd77}) begin
      bad++; $display("FAIL lat2_end dv=%b dout=%0d want 0/77", dv2, dout2);
    end
  endtask

  task automatic test_clear();
    int n = 0;
    EN = 1; WE = 1; ADDR = 2; Din = 13; tick();
    WE = 0; tick();
    total++;
    if ({dv0, dout0} !== {1'b1, 10'd13}) begin
      bad++; $display("FAIL pre_clr_read dv=%b dout=%0d want 1/13", dv0, dout0);
    end
    CLR = 1; WE = 1; Din = 7; ADDR = 5; tick();
    CLR = 0; EN = 0; WE = 0;
    total++;
    if ({busy0, dv0} !== 2'b10) begin
      bad++; $display("FAIL clr_accept busy=%b dv=%b want 1/0", busy0, dv0);
    end
    total++;
    if ({dv2, dout2} !== {1'b1, 10'd13}) begin
      bad++; $display("FAIL inflight dv=%b dout=%0d want 1/13", dv2, dout2);
    end
    EN = 1; ADDR = 2;
    for (int i = 0; i < 100; i++) tick();
    total++;
    if ({busy0, dv0, dout0} !== {1'b1, 1'b0, 10'd13}) begin
      bad++; $display("FAIL busy_ignore busy=%b dv=%b dout=%0d want 1/0/13", busy0, dv0, dout0);
    end
    CLR = 1; tick();
    CLR = 0;
    while (busy0 && n < 400) begin tick(); n++; end
    total++;
    if (n !== 256) begin bad++; $display("FAIL restart_len got=%0d want=256", n); end
    ADDR = 2; tick();
    total++;
    if ({dv0, dout0} !== {1'b1, 10'd0}) begin
      bad++; $display("FAIL post_clr2 dv=%b dout=%0d want 1/0", dv0, dout0);
    end
    ADDR = 5; tick();
    total++;
    if ({dv0, dout0} !== {1'b1, 10'd0}) begin
      bad++; $display("FAIL post_clr5 dv=%b dout=%0d want 1/0", dv0, dout0);
    end
    EN = 0; tick(); tick();
  endtask

  task automatic test_depth_reset();
    EN = 1; WE = 1; ADDR = 250; Din = 9; tick();
    WE = 0; tick();
    total++;
    if ({dv3, dout3} !== {1'b1, 10'h3FF}) begin
      bad++; $display("FAIL oob_read dv=%b dout=%0h want 1/3ff", dv3, dout3);
    end
    total++;
    if ({dv0, dout0} !== {1'b1, 10'd9}) begin
      bad++; $display("FAIL inb_read dv=%b dout=%0d want 1/9", dv0, dout0);
    end
    EN = 0; RST = 0;
    #1;
    total++;
    if ({dv3, dout3, busy3} !== {1'b0, 10'd0, 1'b1}) begin
      bad++; $display("FAIL rst_mid dv=%b dout=%0d busy=%b want 0/0/1", dv3, dout3, busy3);
    end
    total++;
    if ({dv2, dout2} !== {1'b0, 10'd0}) begin
      bad++; $display("FAIL rst_lat2 dv=%b dout=%0d want 0/0", dv2, dout2);
    end
    tick();
    RST = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({dv2, dv3, busy3} !== 3'b001) begin
        bad++; $display("FAIL post_rst i=%0d dv2=%b dv3=%b busy3=%b want 0/0/1", i, dv2, dv3, busy3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wr_mode();
    test_back_to_back();
    test_clear();
    test_depth_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
